serial_paralelo: RTL and testbench
==================================

SERIAL_PARALELO -- requirements
Module: serial_paralelo

Interface
REQ-001 The module SHALL have parameter COMMA, default 8'hBC, giving the alignment/idle byte.
REQ-002 The module SHALL have parameter COMMA_COUNT, default 4, giving the consecutive aligned commas required to declare sync (range 1..15).
REQ-003 The module SHALL have port clk32_f  input  1  serial bit clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port data_in  input  1  serial bit stream, MSB of each byte first.
REQ-006 The module SHALL have port data_out  output  8  last recovered byte, held between byte boundaries.
REQ-007 The module SHALL have port valid_out  output  1  data_out carries payload (non-comma) byte; held with data_out.
REQ-008 The module SHALL have port byte_strobe  output  1  one-cycle pulse on each data_out/valid_out update.
REQ-009 The module SHALL have port active  output  1  byte alignment achieved (state SYNC).

Function
REQ-010 The module SHALL shift every cycle: sr <= {sr[6:0], data_in}; shift_next denotes {sr[6:0], data_in}.
REQ-011 The module SHALL implement a 3-state FSM: SEARCH, ALIGN, SYNC.
REQ-012 In SEARCH, when shift_next == COMMA the module SHALL clear the 3-bit bit counter to 0, set comma_cnt to 1 and enter ALIGN; otherwise it SHALL stay in SEARCH with the counter frozen at 0.
REQ-013 In ALIGN and SYNC the bit counter SHALL increment by 1 every cycle and wrap 7->0; a byte boundary is a cycle with counter == 7.
REQ-014 In ALIGN at a byte boundary: if shift_next == COMMA, comma_cnt SHALL increment; when the incremented value equals COMMA_COUNT the FSM SHALL enter SYNC.
REQ-015 In ALIGN at a byte boundary with shift_next != COMMA, the FSM SHALL return to SEARCH and clear comma_cnt; a comma at an unaligned position is not re-detected in that same cycle.
REQ-016 If COMMA_COUNT == 1, detection in SEARCH SHALL move directly to SYNC.
REQ-017 In SYNC at each byte boundary, data_out SHALL load shift_next, valid_out SHALL load (shift_next != COMMA), and byte_strobe SHALL be 1 for that cycle only.
REQ-018 Latency: the byte whose last bit is sampled at edge N SHALL appear on data_out/valid_out/byte_strobe immediately after edge N.
REQ-019 The cycle entering SYNC SHALL not itself produce a byte_strobe; the first strobe SHALL follow 8 cycles later.
REQ-020 active SHALL be 1 exactly while in SYNC; SYNC SHALL be left only by reset.
REQ-021 Outside SYNC, data_out, valid_out and byte_strobe SHALL hold 0.
REQ-022 comma_cnt SHALL be 4 bits and saturate-free within the 1..15 range.

Reset
REQ-023 Reset assertion SHALL immediately force: state SEARCH, sr 8'h00, bit counter 0, comma_cnt 0, data_out 8'h00, valid_out 0, byte_strobe 0, active 0.
REQ-024 Reset mid-byte or mid-SYNC SHALL discard partial bytes; realignment SHALL restart from SEARCH after deassertion.

Structure
REQ-025 FSM state encoding and the default COMMA value SHALL be defined in a shared package used also by the transmit-side serializer.
REQ-026 The design SHALL be a single module; an optional sub-module comma_detect (8-bit compare) is permitted.

Verification
REQ-027 Reset, then 4 aligned 8'hBC bytes followed by 8'h5A -> active rises at the end of the 4th comma; 8 cycles later data_out=8'h5A, valid_out=1, byte_strobe pulses once.
REQ-028 3 random bits of garbage, then 4 commas, then 8'hA5, 8'hBC -> alignment despite offset; data_out=8'hA5 valid_out=1, then data_out=8'hBC valid_out=0.
REQ-029 2 commas, then 8'h00, then 4 commas -> return to SEARCH after 8'h00, active only after the following 4 commas.
REQ-030 Reset asserted for 1 cycle mid-payload in SYNC -> all outputs 0 at once; active re-asserts only after 4 new commas.
REQ-031 Stream of bytes 8'h00..8'hFF after sync -> each appears once in order, valid_out=0 only for 8'hBC, byte_strobe period exactly 8 cycles.

Source files
------------

// File: rtl/serial_paralelo_pkg.sv
// Shared definitions for the serial link: FSM state encoding and the default comma byte,
// used by both the receive-side deserializer and the transmit-side serializer.
package serial_paralelo_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    SYNC   = 2'd2
  } state_e;

  localparam logic [7:0] DEFAULT_COMMA = 8'hBC;

endpackage

// File: rtl/serial_paralelo_comma_detect.sv
// Combinational comparator flagging when the byte-wide window equals the comma symbol.
module serial_paralelo_comma_detect
  import serial_paralelo_pkg::*;
#(
  parameter logic [7:0] COMMA = DEFAULT_COMMA
) (
  input  logic [7:0] data_i,
  output logic       match_o
);

  assign match_o = (data_i == COMMA);

endmodule

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: finds byte alignment from repeated comma symbols, then
// emits one recovered byte every eight bit clocks.
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter logic [7:0] COMMA       = DEFAULT_COMMA,
  parameter int         COMMA_COUNT = 4
) (
  input  logic       clk32_f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam logic [3:0] CommaTarget = 4'(COMMA_COUNT);

  state_e     state_q, state_d;
  // Only the 7 newest bits need storing; shiftNext completes the byte with data_in.
  logic [6:0] sr_q;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [3:0] commaCnt_q, commaCnt_d;
  logic [7:0] dataOut_q, dataOut_d;
  logic       validOut_q, validOut_d;
  logic       strobe_q, strobe_d;
  logic [7:0] shiftNext;
  logic       isComma;
  logic       atBoundary;

  assign shiftNext  = {sr_q, data_in};
  assign atBoundary = (bitCnt_q == 3'd7);

  serial_paralelo_comma_detect #(
    .COMMA (COMMA)
  ) u_comma_detect (
    .data_i  (shiftNext),
    .match_o (isComma)
  );

  always_ff @(posedge clk32_f or posedge reset) begin
    if (reset) begin
      state_q    <= SEARCH;
      sr_q       <= 7'h00;
      bitCnt_q   <= 3'd0;
      commaCnt_q <= 4'd0;
      dataOut_q  <= 8'h00;
      validOut_q <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= shiftNext[6:0];
      bitCnt_q   <= bitCnt_d;
      commaCnt_q <= commaCnt_d;
      dataOut_q  <= dataOut_d;
      validOut_q <= validOut_d;
      strobe_q   <= strobe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q + 3'd1;
    commaCnt_d = commaCnt_q;
    dataOut_d  = 8'h00;
    validOut_d = 1'b0;
    strobe_d   = 1'b0;

    unique case (state_q)
      SEARCH: begin
        bitCnt_d = 3'd0;
        if (isComma) begin
          commaCnt_d = 4'd1;
          state_d    = (COMMA_COUNT == 1) ? SYNC : ALIGN;
        end
      end
      ALIGN: begin
        // An unaligned comma here is ignored; SEARCH picks it up on a later window.
        if (atBoundary) begin
          if (isComma) begin
            commaCnt_d = commaCnt_q + 4'd1;
            if (commaCnt_d == CommaTarget) begin
              state_d = SYNC;
            end
          end else begin
            commaCnt_d = 4'd0;
            state_d    = SEARCH;
          end
        end
      end
      SYNC: begin
        dataOut_d  = dataOut_q;
        validOut_d = validOut_q;
        if (atBoundary) begin
          dataOut_d  = shiftNext;
          validOut_d = !isComma;
          strobe_d   = 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  assign data_out    = dataOut_q;
  assign valid_out   = validOut_q;
  assign byte_strobe = strobe_q;
  assign active      = (state_q == SYNC);

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed self-checking bench for serial_paralelo: alignment, payload recovery,
// misalignment recovery, mid-stream reset and a full byte sweep.
`timescale 1ns/1ps
module tb_serial_paralelo;

  logic       clk32_f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int checks;
  int failures;

  serial_paralelo #(
    .COMMA       (8'hBC),
    .COMMA_COUNT (4)
  ) dut (
    .clk32_f     (clk32_f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  initial clk32_f = 1'b0;
  always #5 clk32_f = ~clk32_f;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Sends one byte MSB first; when in SYNC, the strobe must fire only after the last bit.
  task automatic applyStimulus(input logic [7:0] b, input logic expectSync);
    for (int i = 7; i >= 0; i--) begin
      data_in = b[i];
      @(posedge clk32_f);
      #1;
      if (expectSync) checkBit("strobe_period", byte_strobe, (i == 0));
    end
  endtask

  task automatic applyBits(input logic [7:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      data_in = b[i];
      @(posedge clk32_f);
      #1;
    end
  endtask

  task automatic doReset();
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (2) @(posedge clk32_f);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_data"}, data_out, 8'h00);
    checkBit({tag, "_valid"}, valid_out, 1'b0);
    checkBit({tag, "_strobe"}, byte_strobe, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    data_in  = 1'b0;

    // Reset state
    #2;
    checkIdle("reset");
    checkBit("reset_active", active, 1'b0);
    doReset();

    // Four aligned commas then 8'h5A
    for (int k = 0; k < 3; k++) applyStimulus(8'hBC, 1'b0);
    checkBit("align3_active", active, 1'b0);
    checkIdle("align3");
    applyStimulus(8'hBC, 1'b0);
    checkBit("sync_active", active, 1'b1);
    checkBit("sync_entry_strobe", byte_strobe, 1'b0);
    checkOutput("sync_entry_data", data_out, 8'h00);
    applyStimulus(8'h5A, 1'b1);
    checkOutput("first_data", data_out, 8'h5A);
    checkBit("first_valid", valid_out, 1'b1);
    applyBits(8'h00, 1);
    checkBit("first_strobe_drop", byte_strobe, 1'b0);
    checkOutput("first_data_hold", data_out, 8'h5A);
    checkBit("first_valid_hold", valid_out, 1'b1);

    // Reset mid-payload while in SYNC
    applyBits(8'h0F, 3);
    reset = 1'b1;
    #1;
    checkIdle("midreset");
    checkBit("midreset_active", active, 1'b0);
    @(posedge clk32_f);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(8'hBC, 1'b0);
    checkBit("resync3_active", active, 1'b0);
    applyStimulus(8'hBC, 1'b0);
    checkBit("resync4_active", active, 1'b1);

    // Three garbage bits, then commas, then A5 and a comma
    doReset();
    applyBits(8'h05, 3);
    for (int k = 0; k < 4; k++) applyStimulus(8'hBC, 1'b0);
    checkBit("offset_active", active, 1'b1);
    applyStimulus(8'hA5, 1'b1);
    checkOutput("offset_dataA5", data_out, 8'hA5);
    checkBit("offset_validA5", valid_out, 1'b1);
    applyStimulus(8'hBC, 1'b1);
    checkOutput("offset_dataBC", data_out, 8'hBC);
    checkBit("offset_validBC", valid_out, 1'b0);

    // Two commas, a non-comma, then four commas
    doReset();
    applyStimulus(8'hBC, 1'b0);
    applyStimulus(8'hBC, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkBit("break_active", active, 1'b0);
    applyStimulus(8'hBC, 1'b0);
    applyStimulus(8'hBC, 1'b0);
    checkBit("break_after2_active", active, 1'b0);
    applyStimulus(8'hBC, 1'b0);
    checkBit("break_after3_active", active, 1'b0);
    checkIdle("break_after3");
    applyStimulus(8'hBC, 1'b0);
    checkBit("break_after4_active", active, 1'b1);

    // Full byte sweep after sync
    doReset();
    for (int k = 0; k < 4; k++) applyStimulus(8'hBC, 1'b0);
    for (int v = 0; v < 256; v++) begin
      applyStimulus(8'(v), 1'b1);
      checkOutput("sweep_data", data_out, 8'(v));
      checkBit("sweep_valid", valid_out, (v != 8'hBC));
    end
    checkBit("sweep_active", active, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
